// File: rtl/systolic_matmul_engine.sv
// Output-stationary NxN systolic matrix multiplier: C = A x B.
// A columns and B rows stream in one beat per cycle, are skewed per lane,
// meet in PE(i,j) and accumulate there; C is drained one row per handshake.
module systolic_matmul_engine #(
    parameter int N         = 4,
    parameter int OP_WIDTH  = 8,
    parameter int ACC_WIDTH = 32,
    parameter int MAX_K     = 256,
    parameter int KW        = $clog2(MAX_K + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [KW-1:0]            k_len,
    output logic                     busy,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N*OP_WIDTH-1:0]    a_col,
    input  logic [N*OP_WIDTH-1:0]    b_row,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N*ACC_WIDTH-1:0]   out_row,
    output logic [$clog2(N)-1:0]     out_idx,
    output logic                     done
);

    localparam int RW = $clog2(N);
    localparam int FW = $clog2(2 * N);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    // Signed multiply-accumulate; the full-width product is sign-extended and the sum wraps.
    function automatic logic signed [ACC_WIDTH-1:0] mac(
        input logic signed [ACC_WIDTH-1:0] acc,
        input logic signed [OP_WIDTH-1:0]  a,
        input logic signed [OP_WIDTH-1:0]  b
    );
        logic signed [2*OP_WIDTH-1:0] prod;
        prod = a * b;
        return acc + ACC_WIDTH'(prod);
    endfunction

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d, cnt_q, cnt_d, k_clamp_s;
    logic [FW-1:0]     flush_q, flush_d;
    logic [RW-1:0]     row_q, row_d;
    logic              busy_q, in_ready_q, out_valid_q, done_q, done_d;
    logic              clear_s, advance_s, beat_s;

    logic signed [OP_WIDTH-1:0]  inj_a_s [N];
    logic signed [OP_WIDTH-1:0]  inj_b_s [N];
    logic signed [OP_WIDTH-1:0]  a_edge_s [N];
    logic signed [OP_WIDTH-1:0]  b_edge_s [N];
    logic signed [OP_WIDTH-1:0]  a_pe_q [N][N];
    logic signed [OP_WIDTH-1:0]  b_pe_q [N][N];
    logic signed [ACC_WIDTH-1:0] acc_q [N][N];

    assign beat_s    = in_ready_q & in_valid;
    assign advance_s = (state_q == S_STREAM) || (state_q == S_FLUSH);
    assign k_clamp_s = (k_len > KW'(MAX_K)) ? KW'(MAX_K) : k_len;

    // Next-state logic: job control, beat/flush/row counters and done pulse.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        flush_d = flush_q;
        row_d   = row_q;
        done_d  = 1'b0;
        clear_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    clear_s = 1'b1;
                    k_d     = k_clamp_s;
                    cnt_d   = '0;
                    flush_d = '0;
                    row_d   = '0;
                    if (k_clamp_s == '0) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_STREAM;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (beat_s) begin
                    cnt_d = cnt_q + KW'(1);
                    if (cnt_q + KW'(1) == k_q) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_STREAM;
                    end
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_FLUSH: begin
                // 2N-1 zero cycles carry the last product into PE(N-1,N-1).
                if (flush_q == FW'(2 * N - 2)) begin
                    state_d = S_DRAIN;
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (row_q == RW'(N - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    row_d = row_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers and registered status outputs derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            flush_q     <= '0;
            row_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
            row_q       <= row_d;
            busy_q      <= (state_d != S_IDLE);
            in_ready_q  <= (state_d == S_STREAM);
            out_valid_q <= (state_d == S_DRAIN);
            done_q      <= done_d;
        end
    end

    // Lane injection: cycles without an accepted beat feed zeros into the array.
    always_comb begin
        for (int l = 0; l < N; l++) begin
            inj_a_s[l] = '0;
            inj_b_s[l] = '0;
            if (beat_s) begin
                inj_a_s[l] = a_col[l*OP_WIDTH +: OP_WIDTH];
                inj_b_s[l] = b_row[l*OP_WIDTH +: OP_WIDTH];
            end else begin
                inj_a_s[l] = '0;
                inj_b_s[l] = '0;
            end
        end
    end

    assign a_edge_s[0] = inj_a_s[0];
    assign b_edge_s[0] = inj_b_s[0];

    for (genvar g = 1; g < N; g++) begin : g_skew
        logic signed [OP_WIDTH-1:0] sa_q [g];
        logic signed [OP_WIDTH-1:0] sb_q [g];

        // Lane g is delayed g cycles so its operands reach the array diagonal in step.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int d = 0; d < g; d++) begin
                    sa_q[d] <= '0;
                    sb_q[d] <= '0;
                end
            end else if (clear_s) begin
                for (int d = 0; d < g; d++) begin
                    sa_q[d] <= '0;
                    sb_q[d] <= '0;
                end
            end else if (advance_s) begin
                sa_q[0] <= inj_a_s[g];
                sb_q[0] <= inj_b_s[g];
                for (int d = 1; d < g; d++) begin
                    sa_q[d] <= sa_q[d-1];
                    sb_q[d] <= sb_q[d-1];
                end
            end
        end

        assign a_edge_s[g] = sa_q[g-1];
        assign b_edge_s[g] = sb_q[g-1];
    end

    // PE grid: A shifts right, B shifts down, each PE accumulates the product it holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_pe_q[i][j] <= '0;
                    b_pe_q[i][j] <= '0;
                    acc_q[i][j]  <= '0;
                end
            end
        end else if (clear_s) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_pe_q[i][j] <= '0;
                    b_pe_q[i][j] <= '0;
                    acc_q[i][j]  <= '0;
                end
            end
        end else if (advance_s) begin
            for (int i = 0; i < N; i++) begin
                a_pe_q[i][0] <= a_edge_s[i];
                b_pe_q[0][i] <= b_edge_s[i];
                for (int j = 1; j < N; j++) begin
                    a_pe_q[i][j] <= a_pe_q[i][j-1];
                    b_pe_q[j][i] <= b_pe_q[j-1][i];
                end
                for (int j = 0; j < N; j++) begin
                    acc_q[i][j] <= mac(acc_q[i][j], a_pe_q[i][j], b_pe_q[i][j]);
                end
            end
        end
    end

    // Result row select; accumulators are frozen while draining so the row is stable.
    always_comb begin
        out_row = '0;
        if (out_valid_q) begin
            for (int j = 0; j < N; j++) begin
                out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc_q[row_q][j];
            end
        end else begin
            out_row = '0;
        end
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_valid_q ? row_q : '0;
    assign done      = done_q;

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Bench for systolic_matmul_engine: random and directed jobs compared with a
// plain matrix-product reference computed from the operand arrays.
module tb_systolic_matmul_engine;

    localparam int N     = 4;
    localparam int OPW   = 8;
    localparam int ACCW  = 32;
    localparam int MAX_K = 256;
    localparam int KW    = $clog2(MAX_K + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [KW-1:0]     k_len;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [N*OPW-1:0]  a_col;
    logic [N*OPW-1:0]  b_row;
    logic              out_valid;
    logic              out_ready;
    logic [N*ACCW-1:0] out_row;
    logic [1:0]        out_idx;
    logic              done;

    int am [N][MAX_K];
    int bm [MAX_K][N];
    int cexp [N][N];
    int checks_total  = 0;
    int checks_passed = 0;

    systolic_matmul_engine #(
        .N(N), .OP_WIDTH(OPW), .ACC_WIDTH(ACCW), .MAX_K(MAX_K), .KW(KW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_idx(out_idx), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < MAX_K; k++) begin
            for (int l = 0; l < N; l++) begin
                am[l][k] = int'($urandom_range(0, 255)) - 128;
                bm[k][l] = int'($urandom_range(0, 255)) - 128;
            end
        end
    endtask

    task automatic fill_const(input int av, input int bv);
        for (int k = 0; k < MAX_K; k++) begin
            for (int l = 0; l < N; l++) begin
                am[l][k] = av;
                bm[k][l] = bv;
            end
        end
    endtask

    // A = identity, B[k][j] = 4k+j+1
    task automatic fill_ident();
        for (int k = 0; k < MAX_K; k++) begin
            for (int l = 0; l < N; l++) begin
                am[l][k] = (l == k) ? 1 : 0;
                bm[k][l] = (k < N) ? (4 * k + l + 1) : 0;
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"}, 128'(busy), 128'(0));
        check_eq({tag, "_in_ready"}, 128'(in_ready), 128'(0));
        check_eq({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check_eq({tag, "_done"}, 128'(done), 128'(0));
        check_eq({tag, "_out_row"}, 128'(out_row), 128'(0));
        check_eq({tag, "_out_idx"}, 128'(out_idx), 128'(0));
    endtask

    task automatic drive_beat(input int idx, input int keff);
        int av, bv;
        for (int l = 0; l < N; l++) begin
            if (idx < keff) begin
                av = am[l][idx];
                bv = bm[idx][l];
            end else begin
                av = int'($urandom);
                bv = int'($urandom);
            end
            a_col[l*OPW +: OPW] = av[OPW-1:0];
            b_row[l*OPW +: OPW] = bv[OPW-1:0];
        end
    endtask

    task automatic run_job(input int k, input int bub, input int stl,
                           input bit hold2, input bit poke, input string tag);
        int keff, idx, accepted, ready_seen, r, hold, budget, s;
        bit fin, poked, v, ordy;
        logic [127:0] ev;
        logic [31:0] cv;
        keff = (k > MAX_K) ? MAX_K : k;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int kk = 0; kk < keff; kk++) s += am[i][kk] * bm[kk][j];
                cexp[i][j] = s;
            end
        end
        idx = 0; accepted = 0; ready_seen = 0; r = 0; hold = 0;
        fin = 1'b0; poked = 1'b0;
        budget = 4 * keff + 300;
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(k);
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < budget && !fin; cyc++) begin
            @(negedge clk);
            if (poke && !poked && idx == 1) begin
                start = 1'b1;
                k_len = KW'(3);
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (in_ready) ready_seen++;
            v = ($urandom_range(0, 99) >= bub);
            in_valid = v;
            drive_beat(idx, keff);
            if (in_ready && v) begin
                accepted++;
                if (idx < keff) idx++;
            end
            if (done) begin
                check_eq({tag, "_rows_before_done"}, 128'(r), 128'(N));
                check_eq({tag, "_done_out_valid"}, 128'(out_valid), 128'(0));
                check_eq({tag, "_done_busy"}, 128'(busy), 128'(0));
                in_valid = 1'b0;
                out_ready = 1'b0;
                fin = 1'b1;
            end else if (out_valid) begin
                if (r < N) begin
                    for (int j = 0; j < N; j++) begin
                        cv = cexp[r][j];
                        ev[j*32 +: 32] = cv;
                    end
                    check_eq({tag, "_out_idx"}, 128'(out_idx), 128'(r));
                    check_eq({tag, "_out_row"}, 128'(out_row), ev);
                end else begin
                    check_eq({tag, "_extra_row"}, 128'(out_idx), 128'(N));
                end
                if (hold2 && r == 2 && hold < 5) begin
                    ordy = 1'b0;
                    hold++;
                end else begin
                    ordy = ($urandom_range(0, 99) >= stl);
                end
                out_ready = ordy;
                if (ordy) r++;
            end else begin
                out_ready = ($urandom_range(0, 1) == 0);
            end
        end
        if (!fin) check_eq({tag, "_timeout"}, 128'(0), 128'(1));
        check_eq({tag, "_beats"}, 128'(accepted), 128'(keff));
        if (keff == 0) check_eq({tag, "_in_ready_seen"}, 128'(ready_seen), 128'(0));
        @(negedge clk);
        check_eq({tag, "_done_one_cycle"}, 128'(done), 128'(0));
        check_eq({tag, "_idle_busy"}, 128'(busy), 128'(0));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
        a_col = '0; b_row = '0; out_ready = 1'b0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;

        fill_ident();           run_job(4, 0, 0, 1'b0, 1'b0, "t1_ident");
        fill_const(-128, -128); run_job(256, 0, 0, 1'b0, 1'b0, "t2_negneg");
        fill_const(127, -128);  run_job(256, 10, 10, 1'b0, 1'b0, "t2_posneg");
        fill_ident();           run_job(4, 50, 0, 1'b0, 1'b0, "t3_bubbles");
        fill_ident();           run_job(4, 0, 0, 1'b1, 1'b0, "t4_hold_r2");
        fill_rand();            run_job(0, 0, 20, 1'b0, 1'b0, "t5_k0");
        fill_rand();            run_job(8, 30, 0, 1'b0, 1'b1, "t5_start_busy");
        fill_rand();            run_job(300, 20, 20, 1'b0, 1'b0, "clamp");

        // Reset in the middle of streaming.
        fill_rand();
        @(negedge clk);
        start = 1'b1; k_len = KW'(10);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; drive_beat(0, 10);
        @(negedge clk);
        drive_beat(1, 10);
        @(negedge clk);
        check_eq("t6_pre_busy", 128'(busy), 128'(1));
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("t6_async");
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_outputs_zero("t6_after");
        fill_ident(); run_job(4, 0, 0, 1'b0, 1'b0, "t6_rerun");

        for (int t = 0; t < 6; t++) begin
            fill_rand();
            run_job(int'($urandom_range(1, 24)), 30, 30, 1'b0, 1'b0, "rand");
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
